// File: rtl/udma_hyper_rx_packer.sv
// HyperBus RX packer: folds the 16-bit PHY read-word stream into 32-bit
// little-endian uDMA RX words, handling an odd start byte, arbitrary byte
// lengths and marking the final word of each transfer.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The output side holds data_o/last_o
// stable while valid_o=1 and ready_i=0; phy_ready_o is only raised when
// the output register can take a new word in the same cycle.
module udma_hyper_rx_packer #(
  parameter int TRANS_SIZE = 16
) (
  input  logic                  periph_clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic                  skip_first_i,
  input  logic [TRANS_SIZE-1:0] len_i,
  input  logic [15:0]           phy_data_i,
  input  logic                  phy_valid_i,
  output logic                  phy_ready_o,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  eot_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [TRANS_SIZE-1:0] rem_q;
  logic [2:0][7:0]       acc_q;
  logic [1:0]            acc_cnt_q;
  logic                  skip_q;
  logic [31:0]           data_q;
  logic                  valid_q;
  logic                  last_q;

  logic                  out_free;
  logic                  phy_ready;
  logic                  beat;
  logic                  n_two;
  logic [TRANS_SIZE-1:0] n_bytes;
  logic [TRANS_SIZE-1:0] rem_next;
  logic [7:0]            b0;
  logic [7:0]            b1;
  logic [2:0]            total;
  logic [4:0][7:0]       pack;
  logic                  flush;

  // Beat sizing and byte placement: new bytes land right after the buffered ones
  always_comb begin
    out_free  = !valid_q || ready_i;
    phy_ready = (state_q == ST_RUN) && (rem_q != '0) && out_free;
    beat      = phy_valid_i && phy_ready;
    // A pending skip or a single remaining byte takes one byte from the word
    n_two     = !skip_q && (rem_q != TRANS_SIZE'(1));
    n_bytes   = n_two ? TRANS_SIZE'(2) : TRANS_SIZE'(1);
    rem_next  = rem_q - n_bytes;
    b0        = skip_q ? phy_data_i[15:8] : phy_data_i[7:0];
    b1        = phy_data_i[15:8];
    total     = {1'b0, acc_cnt_q} + (n_two ? 3'd2 : 3'd1);
    pack      = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(acc_cnt_q)) pack[i] = acc_q[i];
    end
    pack[{1'b0, acc_cnt_q}] = b0;
    if (n_two) pack[{1'b0, acc_cnt_q} + 3'd1] = b1;
    // A byte spilled on the final beat still needs its own output word
    flush = (state_q == ST_RUN) && (rem_q == '0) && (acc_cnt_q != 2'd0) && out_free;
  end

  // Transfer FSM, byte accumulator and registered output word
  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      acc_q     <= '0;
      acc_cnt_q <= 2'd0;
      skip_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else if (clr_i) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      acc_cnt_q <= 2'd0;
      skip_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            rem_q     <= len_i;
            skip_q    <= skip_first_i;
            acc_cnt_q <= 2'd0;
            last_q    <= 1'b0;
            state_q   <= (len_i != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (valid_q && ready_i) valid_q <= 1'b0;
          if (beat) begin
            rem_q  <= rem_next;
            skip_q <= 1'b0;
            if (total >= 3'd4) begin
              data_q    <= pack[3:0];
              valid_q   <= 1'b1;
              last_q    <= (rem_next == '0) && (total == 3'd4);
              acc_q[0]  <= pack[4];
              acc_cnt_q <= total[1:0];
            end else if (rem_next == '0) begin
              data_q    <= pack[3:0];
              valid_q   <= 1'b1;
              last_q    <= 1'b1;
              acc_cnt_q <= 2'd0;
            end else begin
              acc_q     <= pack[2:0];
              acc_cnt_q <= total[1:0];
            end
          end else if (flush) begin
            data_q    <= {24'h0, acc_q[0]};
            valid_q   <= 1'b1;
            last_q    <= 1'b1;
            acc_cnt_q <= 2'd0;
          end
          if (valid_q && ready_i && last_q) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phy_ready_o = phy_ready;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign eot_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_udma_hyper_rx_packer.sv
// Bench for udma_hyper_rx_packer: directed cases plus randomized transfers
// checked against a byte-stream reference model.
module tb_udma_hyper_rx_packer;

  logic        periph_clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        start_i = 1'b0;
  logic        skip_first_i = 1'b0;
  logic [15:0] len_i = '0;
  logic [15:0] phy_data_i = '0;
  logic        phy_valid_i = 1'b0;
  logic        phy_ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        last_o;
  logic        busy_o;
  logic        eot_o;

  int total_cnt = 0;
  int bad_cnt = 0;

  logic [15:0] words [0:31];
  logic [32:0] exp_q [$];

  udma_hyper_rx_packer #(.TRANS_SIZE(16)) dut (
    .periph_clk_i (periph_clk_i),
    .rstn_i       (rstn_i),
    .clr_i        (clr_i),
    .start_i      (start_i),
    .skip_first_i (skip_first_i),
    .len_i        (len_i),
    .phy_data_i   (phy_data_i),
    .phy_valid_i  (phy_valid_i),
    .phy_ready_o  (phy_ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .eot_o        (eot_o)
  );

  // clock
  always #5 periph_clk_i = ~periph_clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: byte stream of the PHY words, skip byte removed, cut to len,
  // chunked into 4-byte little-endian words, last one zero padded.
  task automatic build_expected(input int len, input bit skip);
    logic [7:0] bytes [$];
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      bytes.push_back(words[i][7:0]);
      bytes.push_back(words[i][15:8]);
    end
    if (skip) void'(bytes.pop_front());
    for (int k = 0; k < len; k += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (k + j < len) w[j*8 +: 8] = bytes[k + j];
      exp_q.push_back({(k + 4 >= len), w});
    end
  endtask

  // mode: 0 random handshakes, 1 full rate, 2 backpressure stall, 3 start pulsed mid-run
  task automatic run(input int len, input bit skip, input int mode, input string nm);
    int beats = 0, eots = 0, busy_cyc = 0, cyc = 0, stall = 0;
    bit done = 0, stalled = 0;
    logic [32:0] e;
    build_expected(len, skip);
    @(posedge periph_clk_i); #1;
    start_i = 1'b1; len_i = 16'(len); skip_first_i = skip;
    phy_valid_i = 1'b0; ready_i = 1'b1;
    @(posedge periph_clk_i); #1;
    start_i = 1'b0; len_i = '0; skip_first_i = 1'b0;
    phy_data_i = words[0];
    phy_valid_i = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    ready_i = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
    while (!done && cyc < 2000) begin
      @(negedge periph_clk_i);
      cyc++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check({nm, " extra_word"}, {last_o, data_o}, 33'h0);
        else begin
          e = exp_q.pop_front();
          check({nm, " word"}, {last_o, data_o}, e);
        end
      end
      if (mode == 2 && valid_o && !ready_i) begin
        check({nm, " stall_data"}, data_o, 32'h44332211);
        check({nm, " stall_phy_ready"}, phy_ready_o, 0);
      end
      if (phy_valid_i && phy_ready_o) beats++;
      if (busy_o) busy_cyc++;
      if (eot_o) begin eots++; done = 1; end
      @(posedge periph_clk_i); #1;
      phy_data_i = words[beats];
      if (mode == 0) begin
        phy_valid_i = ($urandom_range(0, 3) != 0);
        ready_i = ($urandom_range(0, 2) != 0);
      end else if (mode == 2) begin
        if (valid_o && !stalled) begin stalled = 1; stall = 5; end
        ready_i = (stall == 0);
        if (stall > 0) stall--;
      end else if (mode == 3) begin
        start_i = (cyc == 2);
        len_i = (cyc == 2) ? 16'd3 : 16'd0;
        skip_first_i = (cyc == 2);
      end
    end
    if (!done) check({nm, " timeout"}, 0, 1);
    start_i = 1'b0; len_i = '0; skip_first_i = 1'b0;
    check({nm, " beats"}, beats, (len == 0) ? 0 : (len + skip + 1) / 2);
    check({nm, " words_left"}, exp_q.size(), 0);
    check({nm, " eot_count"}, eots, 1);
    if (len == 0) check({nm, " busy_cycles"}, busy_cyc, 1);
    // Nothing more may be consumed, produced or signalled once the transfer ended
    phy_valid_i = 1'b1; ready_i = 1'b1;
    repeat (3) begin
      @(negedge periph_clk_i);
      check({nm, " post_idle"}, {eot_o, valid_o, phy_ready_o, busy_o}, 4'b0);
    end
    @(posedge periph_clk_i); #1;
    phy_valid_i = 1'b0;
  endtask

  task automatic fill_seq(input logic [15:0] base);
    for (int i = 0; i < 32; i++) words[i] = base + 16'(i * 16'h2222);
  endtask

  initial begin
    int len;
    bit skip;
    fill_seq(16'h2211);
    // reset
    #1;
    check("reset_outs", {phy_ready_o, data_o, valid_o, last_o, busy_o, eot_o}, 37'h0);
    repeat (3) @(posedge periph_clk_i);
    #1 rstn_i = 1'b1;
    @(negedge periph_clk_i);
    check("after_reset", {phy_ready_o, valid_o, busy_o, eot_o}, 4'h0);

    // aligned: 0x44332211, 0x88776655 last
    fill_seq(16'h2211);
    run(8, 0, 1, "aligned");
    // skip first byte: 0x55443322, 0x00000066 last, 3 beats
    run(5, 1, 1, "skip");
    // odd tail with spill
    words[0] = 16'hBBAA; words[1] = 16'hDDCC;
    run(3, 1, 1, "odd_tail");
    fill_seq(16'h2211);
    run(8, 0, 2, "backpressure");
    run(0, 0, 1, "zero_len");
    run(8, 0, 3, "start_ignored");
    run(1, 0, 1, "len1");
    run(1, 1, 1, "len1_skip");

    // clear after one beat
    @(posedge periph_clk_i); #1;
    start_i = 1'b1; len_i = 16'd8; ready_i = 1'b1;
    @(posedge periph_clk_i); #1;
    start_i = 1'b0; len_i = '0; phy_data_i = words[0]; phy_valid_i = 1'b1;
    @(posedge periph_clk_i); #1;
    phy_valid_i = 1'b0; clr_i = 1'b1;
    @(posedge periph_clk_i); #1;
    clr_i = 1'b0;
    check("clr_state", {valid_o, busy_o, eot_o}, 3'b0);
    repeat (3) begin
      @(negedge periph_clk_i);
      check("clr_no_eot", {eot_o, valid_o}, 2'b0);
    end
    words[0] = 16'h0201; words[1] = 16'h0403;
    run(4, 0, 1, "after_clr");

    // asynchronous reset mid-transfer
    fill_seq(16'h2211);
    @(posedge periph_clk_i); #1;
    start_i = 1'b1; len_i = 16'd8; ready_i = 1'b0;
    @(posedge periph_clk_i); #1;
    start_i = 1'b0; len_i = '0; phy_data_i = words[0]; phy_valid_i = 1'b1;
    repeat (2) @(posedge periph_clk_i);
    #1 phy_data_i = words[2];
    @(posedge periph_clk_i);
    #3 rstn_i = 1'b0;
    #1;
    check("rst_mid", {phy_ready_o, data_o, valid_o, last_o, busy_o, eot_o}, 37'h0);
    phy_valid_i = 1'b0;
    @(posedge periph_clk_i); #1 rstn_i = 1'b1;

    // randomized transfers
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
      len = $urandom_range(0, 40);
      skip = 1'($urandom_range(0, 1));
      run(len, skip, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/udma_hyper_rx_packer.md
Name: udma_hyper_rx_packer

Overview:
Sits downstream of the HyperBus PHY read path, in the periph_clk_i domain. Turns the 16-bit read-word stream from the PHY into 32-bit little-endian uDMA RX words. Handles an odd start byte and arbitrary byte lengths, and marks the final word of each transfer. Its output feeds the RX clock-domain-crossing FIFO towards the uDMA RX channel.

Parameters:
TRANS_SIZE, 16, width of the transfer byte-length field.

Ports:
periph_clk_i  in  1  PHY/peripheral clock.
rstn_i  in  1  Reset.
clr_i  in  1  Synchronous clear; aborts any transfer.
start_i  in  1  Single-cycle pulse; arms a transfer; ignored while busy_o=1.
skip_first_i  in  1  Byte address bit 0; discard the low byte of the first PHY word. Sampled with start_i.
len_i  in  TRANS_SIZE  Number of bytes to deliver. Sampled with start_i.
phy_data_i  in  16  Read word; [7:0] is the earlier byte.
phy_valid_i  in  1  phy_data_i valid.
phy_ready_o  out  1  Packer accepts phy_data_i.
data_o  out  32  Packed word; byte lane 0 is the earliest byte.
valid_o  out  1  data_o valid.
ready_i  in  1  Downstream accepts data_o.
last_o  out  1  data_o holds the final byte(s) of the transfer.
busy_o  out  1  Transfer in progress.
eot_o  out  1  Single-cycle end-of-transfer pulse.

Behaviour:
- Reset and clocking: reset is rstn_i, asynchronous, active-low; clock is periph_clk_i.
- Reset values: phy_ready_o=0, data_o=0, valid_o=0, last_o=0, busy_o=0, eot_o=0. Internal state also resets: byte counter, accumulator (acc, 3 bytes), acc_cnt (0..3), skip flag.
- Byte/length arithmetic:
  - Byte counter rem is TRANS_SIZE bits and is loaded with len_i on start.
  - Each PHY handshake contributes n bytes, where n = 1 (skip pending, or rem=1) or 2, and n never exceeds rem.
  - rem decrements by n on each handshake.
  - Surplus bytes are dropped: the skipped low byte, and the high byte of the final word when rem=1.
- State machine:
  - IDLE --start_i, len_i!=0--> RUN.
  - IDLE --start_i, len_i==0--> DONE. No data is produced.
  - RUN --handshake on the last output word (valid_o & ready_i & last_o)--> DONE.
  - DONE --> IDLE after one cycle. eot_o=1 during DONE.
  - busy_o=1 in RUN and DONE.
  - clr_i takes priority in any state: returns to IDLE, clears valid_o, acc_cnt and rem, and does not pulse eot_o.
- Input handshake:
  - phy_ready_o = RUN && rem!=0 && (!valid_o || ready_i).
  - A PHY beat completes when phy_valid_i & phy_ready_o.
- Packing:
  - New bytes are appended after the acc_cnt buffered bytes.
  - If acc_cnt+n >= 4, or rem reaches 0 on this beat, the output register is loaded on that clock edge. valid_o is asserted the next cycle, giving a latency of 1 cycle.
  - When acc_cnt=3 and n=2, the spilled byte stays in acc lane 0 and acc_cnt becomes 1.
  - Unfilled lanes of a partial final word are 0.
  - last_o is set when the loaded word ends the transfer.
- Output holding:
  - While valid_o=1 and ready_i=0, data_o and last_o hold stable and phy_ready_o=0.
  - An output handshake and a new load in the same cycle keep valid_o=1 with the new data.
- Throughput: one PHY beat per cycle when ready_i stays high.
- Ignored inputs:
  - start_i while busy_o=1 is ignored; in-flight state is untouched.
  - phy_valid_i outside RUN is ignored.

Test Plan:
- Aligned transfer: start, len=8, skip=0; words 0x2211, 0x4433, 0x6655, 0x8877 -> data_o 0x44332211 (last=0), then 0x88776655 (last=1); eot_o pulses once; 4 beats consumed.
- Skip first byte: start, len=5, skip=1; words 0x2211, 0x4433, 0x6655, 0x8877 -> 0x55443322, then 0x00000066 with last=1; only 3 beats accepted; phy_ready_o=0 afterwards.
- Odd tail with spill: len=3, skip=1; words 0xBBAA, 0xDDCC -> single word 0x00DDCCBB with last=1.
- Backpressure: len=8 with ready_i held 0 for 5 cycles after valid_o rises -> data_o stable at 0x44332211; phy_ready_o=0 for the whole stall; no data loss.
- Zero length: start, len=0 -> no valid_o; busy_o high 1 cycle; eot_o pulses 1 cycle after start; start_i pulsed during RUN of an 8-byte transfer -> ignored, output identical to the aligned case.
- Clear and reset mid-transfer: clr_i after 1 beat of len=8 -> valid_o=0, busy_o=0, no eot_o; a following len=4 transfer produces a clean first word. rstn_i low mid-transfer -> all outputs 0 immediately.
